// File: rtl/gpio_bank_ctrl.sv
// gpio_bank_ctrl: memory-mapped GPIO bank with synchronised inputs, edge-flag status and a registered IRQ.
// Define GPIO_DEBOUNCE_EN to add per-bit input debounce of DEBOUNCE_CYCLES cycles.
module gpio_bank_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int PORT_WIDTH = 8,
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 8
`ifdef GPIO_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE_CYCLES = 4
`endif
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            sel_i,
  input  logic [ADDR_WIDTH-1:0]           address_i,
  input  logic [DATA_WIDTH-1:0]           write_data_i,
  input  logic                            mem_write_i,
  output logic [DATA_WIDTH-1:0]           read_data_o,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_in_i,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_out_o,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_oe_o,
  output logic                            irq_o
);
  localparam int PW = PORT_WIDTH;
  localparam int NW = NUM_PORTS * PORT_WIDTH;

  typedef enum logic [1:0] {WARM0, WARM1, RUN} state_t;
  state_t r_state, w_state_nxt;
  logic w_run;

  logic [2:0] w_port, w_off;
  logic w_port_ok, w_wr;
  int w_sh;
  logic [NW-1:0] w_mask, w_wdata, w_w1c;
  logic [NW-1:0] r_out, r_dir, r_status, r_irq_en, r_edge_sel;
  logic [NW-1:0] w_out_nxt, w_dir_nxt, w_status_nxt, w_irq_en_nxt, w_edge_sel_nxt;
  logic [NW-1:0] r_sync1, r_sync2, r_prev, w_stable, w_stable_nxt, w_edge;
  logic [PW-1:0] w_rd;
  logic r_irq;
  logic w_unused;

  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= WARM0;
    else r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_run = 1'b0;
    case (r_state)
      WARM0: w_state_nxt = WARM1;
      WARM1: w_state_nxt = RUN;
      default: begin
        w_state_nxt = RUN;
        w_run = 1'b1;
      end
    endcase
  end

  assign w_port    = address_i[7:5];
  assign w_off     = address_i[4:2];
  assign w_port_ok = int'(w_port) < NUM_PORTS;
  assign w_wr      = sel_i & mem_write_i & w_port_ok;
  assign w_sh      = PW * int'(w_port);
  assign w_mask    = w_wr ? (NW'({PW{1'b1}}) << w_sh) : '0;
  assign w_wdata   = {NUM_PORTS{write_data_i[PW-1:0]}};
  assign w_unused  = ^{address_i, write_data_i};

  assign w_out_nxt      = (w_off == 3'd0) ? (r_out & ~w_mask) | (w_wdata & w_mask) : r_out;
  assign w_dir_nxt      = (w_off == 3'd1) ? (r_dir & ~w_mask) | (w_wdata & w_mask) : r_dir;
  assign w_irq_en_nxt   = (w_off == 3'd4) ? (r_irq_en & ~w_mask) | (w_wdata & w_mask) : r_irq_en;
  assign w_edge_sel_nxt = (w_off == 3'd5) ? (r_edge_sel & ~w_mask) | (w_wdata & w_mask) : r_edge_sel;
  assign w_w1c          = (w_off == 3'd3) ? (w_wdata & w_mask) : '0;

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] r_cnt [NW];
  logic [NW-1:0] r_stable, w_diff, w_done;

  assign w_diff = r_sync2 ^ r_stable;

  always_comb begin
    w_done = '0;
    for (int i = 0; i < NW; i++)
      w_done[i] = w_diff[i] && (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_stable <= '0;
      for (int i = 0; i < NW; i++) r_cnt[i] <= '0;
    end else begin
      r_stable <= w_stable_nxt;
      for (int i = 0; i < NW; i++)
        r_cnt[i] <= (w_diff[i] && !w_done[i]) ? r_cnt[i] + CW'(1) : '0;
    end

  assign w_stable     = r_stable;
  assign w_stable_nxt = (r_stable & ~w_done) | (r_sync2 & w_done);
`else
  assign w_stable     = r_sync2;
  assign w_stable_nxt = r_sync1;
`endif

  // EDGE_SEL bit 0 flags a new value of 1 (rising), bit 1 flags a new value of 0 (falling)
  assign w_edge       = {NW{w_run}} & (w_stable ^ r_prev) & (w_stable ^ r_edge_sel);
  assign w_status_nxt = (r_status & ~w_w1c) | w_edge;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_out      <= '0;
      r_dir      <= '0;
      r_status   <= '0;
      r_irq_en   <= '0;
      r_edge_sel <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_prev     <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_out      <= w_out_nxt;
      r_dir      <= w_dir_nxt;
      r_status   <= w_status_nxt;
      r_irq_en   <= w_irq_en_nxt;
      r_edge_sel <= w_edge_sel_nxt;
      r_sync1    <= gpio_in_i;
      r_sync2    <= r_sync1;
      // During warm-up prev is primed with the value the stable input is about to take,
      // so pins already high at reset release never look like an edge once RUN begins.
      r_prev     <= w_run ? w_stable : w_stable_nxt;
      r_irq      <= |(w_status_nxt & w_irq_en_nxt);
    end

  always_comb begin
    w_rd = '0;
    case (w_off)
      3'd0: w_rd = PW'(r_out >> w_sh);
      3'd1: w_rd = PW'(r_dir >> w_sh);
      3'd2: w_rd = PW'(w_stable >> w_sh);
      3'd3: w_rd = PW'(r_status >> w_sh);
      3'd4: w_rd = PW'(r_irq_en >> w_sh);
      3'd5: w_rd = PW'(r_edge_sel >> w_sh);
      default: w_rd = '0;
    endcase
  end

  assign read_data_o = (sel_i && w_port_ok) ? DATA_WIDTH'(w_rd) : '0;
  assign gpio_out_o  = r_out;
  assign gpio_oe_o   = r_dir;
  assign irq_o       = r_irq;
endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// tb_gpio_bank_ctrl: directed scoreboard bench for gpio_bank_ctrl (2 ports x 8 bits).
module tb_gpio_bank_ctrl;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel_i = 1'b0;
  logic [7:0]  address_i = '0;
  logic [31:0] write_data_i = '0;
  logic        mem_write_i = 1'b0;
  logic [31:0] read_data_o;
  logic [15:0] gpio_in_i = 16'hFFFF;
  logic [15:0] gpio_out_o;
  logic [15:0] gpio_oe_o;
  logic        irq_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  gpio_bank_ctrl dut (
    .clk(clk),
    .reset(reset),
    .sel_i(sel_i),
    .address_i(address_i),
    .write_data_i(write_data_i),
    .mem_write_i(mem_write_i),
    .read_data_o(read_data_o),
    .gpio_in_i(gpio_in_i),
    .gpio_out_o(gpio_out_o),
    .gpio_oe_o(gpio_oe_o),
    .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic push(input string t, input logic [31:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    sel_i = 1'b1;
    mem_write_i = 1'b1;
    address_i = a;
    write_data_i = d;
    @(negedge clk);
    sel_i = 1'b0;
    mem_write_i = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic s, output logic [31:0] v);
    sel_i = s;
    mem_write_i = 1'b0;
    address_i = a;
    #1 v = read_data_o;
    sel_i = 1'b0;
  endtask

  task automatic pr(input string t, input logic [7:0] a, input logic [31:0] e);
    logic [31:0] v;
    push(t, e);
    rd(a, 1'b1, v);
    chk(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    repeat (3) @(negedge clk);
    push("rst_irq", 32'd0);   chk({31'd0, irq_o});
    push("rst_oe", 32'd0);    chk({16'd0, gpio_oe_o});
    push("rst_out", 32'd0);   chk({16'd0, gpio_out_o});
    reset = 1'b1;
    repeat (4) @(negedge clk);
    pr("rst_status_p0", 8'h0C, 32'd0);
    pr("rst_status_p1", 8'h2C, 32'd0);
    push("rst_irq_run", 32'd0); chk({31'd0, irq_o});
    repeat (4 + LAT) @(negedge clk);
    pr("in_p0_high", 8'h08, 32'h0000_00FF);
    pr("in_p1_high", 8'h28, 32'h0000_00FF);

    gpio_in_i = 16'h0000;
    repeat (6 + LAT) @(negedge clk);
`ifndef GPIO_DEBOUNCE_EN
    pr("fall_ignored_p0", 8'h0C, 32'd0);
`endif
    wr(8'h0C, 32'hFF);
    wr(8'h2C, 32'hFF);
    pr("in_p0_low", 8'h08, 32'd0);

    wr(8'h20, 32'hFFFF_FFA5);
    push("out_p1", 32'h0000_A500); chk({16'd0, gpio_out_o});
    wr(8'h24, 32'h0000_00FF);
    push("oe_p1", 32'h0000_FF00);  chk({16'd0, gpio_oe_o});
    pr("rd_out_p1", 8'h20, 32'h0000_00A5);
    pr("rd_dir_p1", 8'h24, 32'h0000_00FF);
    pr("rd_out_p0", 8'h00, 32'd0);

    wr(8'h10, 32'h01);
    wr(8'h14, 32'h00);
    pr("rd_irqen_p0", 8'h10, 32'h01);
    gpio_in_i = 16'h0001;
    @(posedge clk);
    @(posedge clk);
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    pr("in_bit0_sync", 8'h08, 32'h01);
    pr("status_not_yet", 8'h0C, 32'd0);
    @(posedge clk);
    @(negedge clk);
    pr("status_rise", 8'h0C, 32'h01);
    @(posedge clk);
    @(negedge clk);
    push("irq_set", 32'd1); chk({31'd0, irq_o});
    wr(8'h0C, 32'h01);
    push("irq_clr", 32'd0); chk({31'd0, irq_o});
    pr("status_clr", 8'h0C, 32'd0);

    wr(8'h14, 32'h02);
    gpio_in_i = 16'h0003;
    repeat (5 + LAT) @(negedge clk);
    pr("rise_bit1_ignored", 8'h0C, 32'd0);
    gpio_in_i = 16'h0001;
    repeat (5 + LAT) @(negedge clk);
    pr("fall_bit1_flag", 8'h0C, 32'h02);
    push("irq_masked", 32'd0); chk({31'd0, irq_o});
    wr(8'h0C, 32'h02);
    pr("status_clr2", 8'h0C, 32'd0);

    gpio_in_i = 16'h0000;
    repeat (5 + LAT) @(negedge clk);
    pr("fall_bit0_ignored", 8'h0C, 32'd0);
    gpio_in_i = 16'h0001;
    @(posedge clk);
    @(posedge clk);
    repeat (LAT) @(posedge clk);
    wr(8'h0C, 32'h01);
    pr("set_wins", 8'h0C, 32'h01);
    push("irq_set_wins", 32'd1); chk({31'd0, irq_o});

    wr(8'hA0, 32'hFF);
    pr("port5_rd", 8'hA0, 32'd0);
    push("port5_no_out", 32'h0000_A500); chk({16'd0, gpio_out_o});
    wr(8'h18, 32'hFF);
    pr("reserved_rd", 8'h18, 32'd0);
    push("reserved_no_oe", 32'h0000_FF00); chk({16'd0, gpio_oe_o});
    push("sel0_rd", 32'd0);
    rd(8'h20, 1'b0, v);
    chk(v);
    pr("in_p1_zero", 8'h28, 32'd0);

`ifdef GPIO_DEBOUNCE_EN
    gpio_in_i = 16'h0005;
    repeat (3) @(negedge clk);
    gpio_in_i = 16'h0001;
    repeat (10) @(negedge clk);
    pr("glitch_ignored", 8'h08, 32'h01);
    gpio_in_i = 16'h0005;
    repeat (2 + LAT + 1) @(negedge clk);
    pr("stable_change", 8'h08, 32'h05);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
